exe_muldiv: RTL

EXE_MULDIV -- requirements
Module: exe_muldiv

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/exe_muldiv_if.sv | 22 ++
 rtl/muldiv_divider.sv | 45 ++++
 rtl/exe_muldiv.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state encodings and a sign/magnitude helper for the
// iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [5:0] OP_MFHI  = 6'h10;
  localparam logic [5:0] OP_MTHI  = 6'h11;
  localparam logic [5:0] OP_MFLO  = 6'h12;
  localparam logic [5:0] OP_MTLO  = 6'h13;
  localparam logic [5:0] OP_MULT  = 6'h18;
  localparam logic [5:0] OP_MULTU = 6'h19;
  localparam logic [5:0] OP_DIV   = 6'h1A;
  localparam logic [5:0] OP_DIVU  = 6'h1B;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Magnitude of a 32-bit value; only negative when the op is signed.
  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/exe_muldiv_if.sv
// Pipeline-side bus of the multiply/divide unit: flush, operands and op code
// from ID/EXE, stall request and HI/LO/move-from results back.
interface exe_muldiv_if;
  logic        FLUSH;
  logic [31:0] OperandA_IN;
  logic [31:0] OperandB_IN;
  logic [5:0]  ALUControl_IN;
  logic        Busy_OUT;
  logic [31:0] HI_OUT;
  logic [31:0] LO_OUT;
  logic [31:0] Result_OUT;

  modport master (
    output FLUSH, OperandA_IN, OperandB_IN, ALUControl_IN,
    input  Busy_OUT, HI_OUT, LO_OUT, Result_OUT
  );

  modport slave (
    input  FLUSH, OperandA_IN, OperandB_IN, ALUControl_IN,
    output Busy_OUT, HI_OUT, LO_OUT, Result_OUT
  );
endinterface

// File: rtl/muldiv_divider.sv
// Restoring divider datapath, one quotient bit per step. The dividend is
// shifted out of the quotient register into the partial remainder while the
// quotient bits shift in. Next-state values are exported so the controller
// can commit the final result on the same edge as the last step.
module muldiv_divider (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic        i_step,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic [31:0] o_quo_nxt,
  output logic [31:0] o_rem_nxt
);

  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [32:0] w_shift;
  logic [31:0] w_diff;
  logic        w_ge;

  // Trial subtract of the shifted remainder; restore by keeping the shift.
  always_comb begin
    w_shift   = {r_rem, r_quo[31]};
    w_ge      = (w_shift >= {1'b0, i_divisor});
    w_diff    = w_shift[31:0] - i_divisor;
    o_rem_nxt = w_ge ? w_diff : w_shift[31:0];
    o_quo_nxt = {r_quo[30:0], w_ge};
  end

  // Load the dividend on start, advance one bit per step.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rem <= 32'd0;
      r_quo <= 32'd0;
    end else if (i_load) begin
      r_rem <= 32'd0;
      r_quo <= i_dividend;
    end else if (i_step) begin
      r_rem <= o_rem_nxt;
      r_quo <= o_quo_nxt;
    end
  end

endmodule

// File: rtl/exe_muldiv.sv
// EXE-stage multiply/divide unit with HI/LO registers.
// Build option: MULDIV_FAST_MUL_EN selects a single-cycle multiply; without
// it the multiply is a 32-cycle shift-add. Divide is always 32 cycles.
//
// state | meaning
// IDLE  | accept mul/div start, MTHI/MTLO writes
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
// DONE  | result committed; held op code ignored, back to IDLE
module exe_muldiv
  import muldiv_pkg::*;
(
  input  logic         CLOCK,
  input  logic         RESET,
  exe_muldiv_if.slave  bus
);

  logic [1:0]  r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_opa;
  logic [31:0] r_opb;
  logic        r_signed;
  logic [63:0] r_prod;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_is_mul, w_is_div, w_sgn_in, w_start_div, w_last, w_neg;
  logic [31:0] w_mcand, w_divisor, w_quo_nxt, w_rem_nxt, w_quo_fix, w_rem_fix;
  logic [32:0] w_add;
  logic [63:0] w_prod_nxt, w_prod_fix;
`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] w_fast_mag, w_fast_prod;
`endif

  // Op decode, shift-add step and sign correction of the finished results.
  always_comb begin
    w_is_mul    = (bus.ALUControl_IN == OP_MULT) || (bus.ALUControl_IN == OP_MULTU);
    w_is_div    = (bus.ALUControl_IN == OP_DIV)  || (bus.ALUControl_IN == OP_DIVU);
    w_sgn_in    = (bus.ALUControl_IN == OP_MULT) || (bus.ALUControl_IN == OP_DIV);
    w_start_div = (r_state == ST_IDLE) && w_is_div && !bus.FLUSH;
    w_last      = (r_cnt == 5'd0);
    w_neg       = r_signed && (r_opa[31] ^ r_opb[31]);
    w_mcand     = mag32(r_opa, r_signed);
    w_divisor   = mag32(r_opb, r_signed);
    w_add       = {1'b0, r_prod[63:32]} + (r_prod[0] ? {1'b0, w_mcand} : 33'd0);
    w_prod_nxt  = {w_add, r_prod[31:1]};
    w_prod_fix  = w_neg ? (64'd0 - w_prod_nxt) : w_prod_nxt;
    // Divide by zero reports all-ones quotient regardless of signs; the
    // remainder path already reproduces the dividend.
    w_quo_fix   = (r_opb == 32'd0) ? 32'hFFFF_FFFF :
                  (w_neg ? (32'd0 - w_quo_nxt) : w_quo_nxt);
    w_rem_fix   = (r_signed && r_opa[31]) ? (32'd0 - w_rem_nxt) : w_rem_nxt;
`ifdef MULDIV_FAST_MUL_EN
    w_fast_mag  = {32'd0, mag32(bus.OperandA_IN, w_sgn_in)} *
                  {32'd0, mag32(bus.OperandB_IN, w_sgn_in)};
    w_fast_prod = (w_sgn_in && (bus.OperandA_IN[31] ^ bus.OperandB_IN[31])) ?
                  (64'd0 - w_fast_mag) : w_fast_mag;
`endif
  end

  muldiv_divider u_divider (
    .i_clk      (CLOCK),
    .i_rst_n    (RESET),
    .i_load     (w_start_div),
    .i_step     ((r_state == ST_DIV) && !bus.FLUSH),
    .i_dividend (mag32(bus.OperandA_IN, w_sgn_in)),
    .i_divisor  (w_divisor),
    .o_quo_nxt  (w_quo_nxt),
    .o_rem_nxt  (w_rem_nxt)
  );

  // Control FSM, operand capture, multiply accumulator and HI/LO updates.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 5'd0;
      r_opa    <= 32'd0;
      r_opb    <= 32'd0;
      r_signed <= 1'b0;
      r_prod   <= 64'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else if (bus.FLUSH) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_mul) begin
`ifdef MULDIV_FAST_MUL_EN
            r_hi    <= w_fast_prod[63:32];
            r_lo    <= w_fast_prod[31:0];
            r_state <= ST_DONE;
`else
            r_opa    <= bus.OperandA_IN;
            r_opb    <= bus.OperandB_IN;
            r_signed <= w_sgn_in;
            r_prod   <= {32'd0, mag32(bus.OperandB_IN, w_sgn_in)};
            r_cnt    <= 5'd31;
            r_state  <= ST_MUL;
`endif
          end else if (w_is_div) begin
            r_opa    <= bus.OperandA_IN;
            r_opb    <= bus.OperandB_IN;
            r_signed <= w_sgn_in;
            r_cnt    <= 5'd31;
            r_state  <= ST_DIV;
          end else if (bus.ALUControl_IN == OP_MTHI) begin
            r_hi <= bus.OperandA_IN;
          end else if (bus.ALUControl_IN == OP_MTLO) begin
            r_lo <= bus.OperandA_IN;
          end
        end
        ST_MUL: begin
          r_prod <= w_prod_nxt;
          r_cnt  <= r_cnt - 5'd1;
          if (w_last) begin
            r_hi    <= w_prod_fix[63:32];
            r_lo    <= w_prod_fix[31:0];
            r_state <= ST_DONE;
          end
        end
        ST_DIV: begin
          r_cnt <= r_cnt - 5'd1;
          if (w_last) begin
            r_lo    <= w_quo_fix;
            r_hi    <= w_rem_fix;
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Stall request and move-from result path.
  always_comb begin
    bus.Busy_OUT = RESET &&
                   (((r_state == ST_IDLE) && (w_is_mul || w_is_div)) ||
                    (r_state == ST_MUL) || (r_state == ST_DIV));
    bus.Result_OUT = 32'd0;
    if (bus.ALUControl_IN == OP_MFHI)      bus.Result_OUT = r_hi;
    else if (bus.ALUControl_IN == OP_MFLO) bus.Result_OUT = r_lo;
  end

  assign bus.HI_OUT = r_hi;
  assign bus.LO_OUT = r_lo;

endmodule
